// File: rtl/pipe_defs_pkg.sv
// ---------------------------------------------------------------------------
// pipe_defs_pkg
//   Shared pipeline definitions for the 5-stage core.
//   - Instruction field slice macros (OP/RD/RS/RT/ALUOP).
//   - Opcode and ALU-op constants.
//   - md_state_t: state encoding of the multiply/divide controller.
//   - reads_reg(): register read-set decode of an instruction. It is shared
//     with future scoreboard logic, so it stays free of stage-specific state.
// ---------------------------------------------------------------------------
`define PD_OP(ir)    ir[31:27]
`define PD_RD(ir)    ir[26:22]
`define PD_RS(ir)    ir[21:17]
`define PD_RT(ir)    ir[16:12]
`define PD_ALUOP(ir) ir[6:2]

package pipe_defs_pkg;

   localparam logic [4:0] OP_ALU  = 5'd0;
   localparam logic [4:0] OP_BNE  = 5'd2;
   localparam logic [4:0] OP_JR   = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_BLT  = 5'd6;
   localparam logic [4:0] OP_SW   = 5'd7;
   localparam logic [4:0] OP_LW   = 5'd8;

   localparam logic [4:0] ALUOP_MUL = 5'b00110;
   localparam logic [4:0] ALUOP_DIV = 5'b00111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } md_state_t;

   // True when an instruction with the given fields reads register r.
   // Register 0 is hard-wired to zero and never creates a dependency.
   // sw reads only its base register here: the store data is picked up
   // later by the M-stage bypass, so it cannot cause a load-use stall.
   function automatic logic reads_reg(input logic [4:0] op,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic [4:0] r);
      logic hit;
      hit = 1'b0;
      if (r != 5'd0) begin
         case (op)
            OP_ALU:                hit = (rs == r) || (rt == r);
            OP_ADDI, OP_LW, OP_SW: hit = (rs == r);
            OP_BNE, OP_BLT:        hit = (rd == r) || (rs == r);
            OP_JR:                 hit = (rd == r);
            default:               hit = 1'b0;
         endcase
      end
      return hit;
   endfunction

endpackage

// File: rtl/md_countdown.sv
// ---------------------------------------------------------------------------
// md_countdown
//   Down-counter timing the multiply/divide latency.
//   Ports:
//     clock     in  pipeline clock, rising edge
//     reset_n   in  asynchronous active-low reset (count -> 0)
//     load      in  load load_val
//     load_val  in  value to load (CNT_W bits)
//     dec       in  decrement by one; holds at 0 (never wraps)
//     clr       in  force count to 0 (highest priority)
//     is_zero   out count == 0
//     is_one    out count == 1
// ---------------------------------------------------------------------------
module md_countdown #(
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   input  logic             clr,
   output logic             is_zero,
   output logic             is_one
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_zero = (cnt_q == '0);
   assign is_one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_control.sv
// ---------------------------------------------------------------------------
// hazard_stall_control
//   Stall/bubble generator for hazards the forwarding network cannot hide:
//   load-use (lw in DX feeding the instruction in FD) and multi-cycle
//   mul/div issued from DX whose result is later injected into X/M.
//   Ports:
//     clock     in   pipeline clock, rising edge
//     reset_n   in   asynchronous active-low reset
//     FDIR      in   instruction in F/D latch
//     DXIR      in   instruction in D/X latch
//     flush     in   taken branch/jump resolved in X this cycle
//     stallFD   out  hold PC and F/D latch
//     bubbleDX  out  load nop into D/X latch next edge
//     md_start  out  one-cycle start pulse for the multiplier/divider
//     md_isDiv  out  qualifies md_start: 1=div, 0=mul
//     md_busy   out  mul/div in flight
//     md_done   out  one-cycle pulse: inject mdIR into X/M this cycle
//     mdIR      out  latched mul/div instruction, 0 unless md_done
// ---------------------------------------------------------------------------
module hazard_stall_control
   import pipe_defs_pkg::*;
#(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] FDIR,
   input  logic [31:0] DXIR,
   input  logic        flush,
   output logic        stallFD,
   output logic        bubbleDX,
   output logic        md_start,
   output logic        md_isDiv,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] mdIR
);

   // The DONE cycle is the MD_LATENCY-th after start, so BUSY lasts
   // MD_LATENCY-1 cycles: load that count and leave BUSY when it hits 1.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

   md_state_t   state_q, state_d;
   logic [31:0] mdir_q, mdir_d;

   logic cnt_load, cnt_dec, cnt_clr;
   logic cnt_zero, cnt_one;

   logic dx_is_md;
   logic load_use;

   // Low FD bits carry no register specifiers; kept as a named sink.
   logic fd_unused;
   assign fd_unused = ^FDIR[11:0];

   md_countdown #(
      .CNT_W (CNT_W)
   ) u_md_countdown (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (CNT_LOAD),
      .dec      (cnt_dec),
      .clr      (cnt_clr),
      .is_zero  (cnt_zero),
      .is_one   (cnt_one)
   );

   // A mul/div targeting r0 has no architectural effect, so it is a nop.
   assign dx_is_md = (`PD_OP(DXIR) == OP_ALU) &&
                     ((`PD_ALUOP(DXIR) == ALUOP_MUL) || (`PD_ALUOP(DXIR) == ALUOP_DIV)) &&
                     (`PD_RD(DXIR) != 5'd0);

   assign load_use = (`PD_OP(DXIR) == OP_LW) && (`PD_RD(DXIR) != 5'd0) &&
                     reads_reg(`PD_OP(FDIR), `PD_RD(FDIR), `PD_RS(FDIR),
                               `PD_RT(FDIR), `PD_RD(DXIR));

   always_comb begin
      state_d  = state_q;
      mdir_d   = mdir_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_clr  = 1'b0;
      stallFD  = 1'b0;
      bubbleDX = 1'b0;
      md_start = 1'b0;
      md_isDiv = 1'b0;
      md_busy  = 1'b0;
      md_done  = 1'b0;
      mdIR     = 32'd0;

      case (state_q)
         IDLE: begin
            if (flush) begin
               // Squash the wrong-path DX instruction; FD is refetched anyway.
               bubbleDX = 1'b1;
            end else if (dx_is_md) begin
               md_start = 1'b1;
               md_isDiv = (`PD_ALUOP(DXIR) == ALUOP_DIV);
               mdir_d   = DXIR;
               stallFD  = 1'b1;
               bubbleDX = 1'b1;
               cnt_load = 1'b1;
               state_d  = BUSY;
            end else if (load_use) begin
               stallFD  = 1'b1;
               bubbleDX = 1'b1;
            end
         end
         BUSY: begin
            // flush cannot arrive here: X only holds bubbles while busy.
            md_busy  = 1'b1;
            stallFD  = 1'b1;
            bubbleDX = 1'b1;
            cnt_dec  = 1'b1;
            if (cnt_one || cnt_zero) begin
               state_d = DONE;
            end
         end
         DONE: begin
            md_done  = 1'b1;
            mdIR     = mdir_q;
            stallFD  = 1'b1;
            bubbleDX = 1'b1;
            cnt_clr  = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_clr = 1'b1;
         end
      endcase

      // Outputs must read 0 the instant reset asserts, even though DX/FD
      // may still present a hazard combinationally.
      if (!reset_n) begin
         stallFD  = 1'b0;
         bubbleDX = 1'b0;
         md_start = 1'b0;
         md_isDiv = 1'b0;
         md_busy  = 1'b0;
         md_done  = 1'b0;
         mdIR     = 32'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         mdir_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         mdir_q  <= mdir_d;
      end
   end

endmodule
